// File: rtl/clock_pkg.sv
// Shared definitions for the digital-clock display path.
// Contents: default field width, field index constants, per-field value
// limits, active-high 7-segment codes (gfedcba) and small helper functions.
package clock_pkg;

    localparam int unsigned FIELD_W = 6;

    // Field indices within the packed time vectors
    localparam int unsigned F_SEC  = 0;
    localparam int unsigned F_MIN  = 1;
    localparam int unsigned F_HOUR = 2;

    // Exclusive upper limits of a valid field value
    localparam int unsigned LIM_SEC   = 60;
    localparam int unsigned LIM_MIN   = 60;
    localparam int unsigned LIM_HOUR  = 24;
    localparam int unsigned LIM_OTHER = 100;

    // Active-high segment codes, bit 6 = g ... bit 0 = a
    localparam logic [6:0] SEG_DASH  = 7'h40;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    typedef enum logic {
        PHASE_OFF = 1'b0,
        PHASE_ON  = 1'b1
    } blink_phase_t;

    function automatic int unsigned field_limit(input int unsigned k);
        if (k == F_SEC)       return LIM_SEC;
        else if (k == F_MIN)  return LIM_MIN;
        else if (k == F_HOUR) return LIM_HOUR;
        else                  return LIM_OTHER;
    endfunction

    // Active-high digit table; codes above 9 never reach here after the range check
    function automatic logic [6:0] seg_digit(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h3F;
            4'd1:    return 7'h06;
            4'd2:    return 7'h5B;
            4'd3:    return 7'h4F;
            4'd4:    return 7'h66;
            4'd5:    return 7'h6D;
            4'd6:    return 7'h7D;
            4'd7:    return 7'h07;
            4'd8:    return 7'h7F;
            4'd9:    return 7'h6F;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/seg7_digit_enc.sv
// Combinational single-digit 7-segment encoder.
// Ports:
//   digit  in  4  BCD digit 0..9
//   blank  in  1  force all segments off (highest priority)
//   dash   in  1  show segment g only
//   seg    out 7  segment drive gfedcba, polarity set by SEG_ACT_LOW
module seg7_digit_enc
    import clock_pkg::*;
#(
    parameter int unsigned SEG_ACT_LOW = 1
) (
    input  logic [3:0] digit,
    input  logic       blank,
    input  logic       dash,
    output logic [6:0] seg
);

    logic [6:0] seg_act_high;

    always_comb begin
        if (blank)
            seg_act_high = SEG_BLANK;
        else if (dash)
            seg_act_high = SEG_DASH;
        else
            seg_act_high = seg_digit(digit);

        seg = (SEG_ACT_LOW != 0) ? ~seg_act_high : seg_act_high;
    end

endmodule

// File: rtl/time_display_ctrl.sv
// Registered display front-end for the digital clock.
// Selects live time or the set/alarm edit buffer, range-checks each field,
// optionally shows hours in 12-hour form, blinks the field under edit and
// drives two 7-segment digits per field through a registered output stage.
// Ports:
//   clk         in   1               system clock
//   rst         in   1               synchronous active-high reset
//   time_live   in   FIELDS*FIELD_W  running time, field k at [k*FIELD_W +: FIELD_W]
//   time_edit   in   FIELDS*FIELD_W  set/alarm buffer, same packing
//   set_en      in   1               time-set mode
//   alarm_en    in   1               alarm-set mode
//   edit_field  in   2               0 none, k+1 = field k under edit
//   mode_12h    in   1               show hours in 12-hour form
//   all_hex     out  FIELDS*14       ones digit at [14k +: 7], tens at [14k+7 +: 7]
//   pm_flag     out  1               displayed hour >= 12 (0 if hour out of range)
//   blink_on    out  1               blink phase, 1 = edited field visible
module time_display_ctrl
    import clock_pkg::*;
#(
    parameter int unsigned FIELDS      = 3,
    parameter int unsigned FIELD_W     = clock_pkg::FIELD_W,
    parameter int unsigned BLINK_DIV   = 25_000_000,
    parameter int unsigned SEG_ACT_LOW = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [FIELDS*FIELD_W-1:0] time_live,
    input  logic [FIELDS*FIELD_W-1:0] time_edit,
    input  logic                      set_en,
    input  logic                      alarm_en,
    input  logic [1:0]                edit_field,
    input  logic                      mode_12h,
    output logic [FIELDS*14-1:0]      all_hex,
    output logic                      pm_flag,
    output logic                      blink_on
);

    localparam int unsigned CNT_W     = $clog2(BLINK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_DIV - 1);
    localparam logic [6:0] BLANK_OUT  = (SEG_ACT_LOW != 0) ? 7'h7F : 7'h00;

    logic [CNT_W-1:0]          cnt;
    blink_phase_t              phase;
    logic                      edit_mode;
    logic                      edit_mode_q;
    logic [1:0]                edit_field_q;
    logic                      restart;
    logic                      blink_vis;
    logic [FIELDS*FIELD_W-1:0] src;
    logic [FIELDS*14-1:0]      hex_d;
    logic                      pm_d;

    assign edit_mode = set_en | alarm_en;
    assign src       = edit_mode ? time_edit : time_live;
    assign restart   = edit_mode & (~edit_mode_q | (edit_field != edit_field_q));
    // A restart forces visibility in the same cycle so a newly selected field
    // is never shown blanked by the stale phase of the previous selection.
    assign blink_vis = (phase == PHASE_ON) | restart;
    assign blink_on  = (phase == PHASE_ON);

    for (genvar k = 0; k < FIELDS; k++) begin : g_field
        logic [FIELD_W-1:0] val;
        logic [31:0]        val32;
        logic [31:0]        shown;
        logic               out_of_range;
        logic               blank;
        logic [3:0]         tens;
        logic [3:0]         ones;

        assign val = src[k*FIELD_W +: FIELD_W];

        always_comb begin
            val32        = 32'(val);
            out_of_range = (val32 >= field_limit(k));
            shown        = val32;
            // Range check above sees the raw value; conversion only affects digits.
            if ((k == F_HOUR) && mode_12h) begin
                if (val32 == 32'd0)
                    shown = 32'd12;
                else if (val32 > 32'd12)
                    shown = val32 - 32'd12;
            end
            tens = 4'(shown / 32'd10);
            ones = 4'(shown % 32'd10);
        end

        assign blank = edit_mode && (32'(edit_field) == 32'(k + 1)) && !blink_vis;

        seg7_digit_enc #(
            .SEG_ACT_LOW(SEG_ACT_LOW)
        ) u_ones (
            .digit(ones),
            .blank(blank),
            .dash (out_of_range),
            .seg  (hex_d[14*k +: 7])
        );

        seg7_digit_enc #(
            .SEG_ACT_LOW(SEG_ACT_LOW)
        ) u_tens (
            .digit(tens),
            .blank(blank),
            .dash (out_of_range),
            .seg  (hex_d[14*k+7 +: 7])
        );
    end

    if (FIELDS > F_HOUR) begin : g_pm
        logic [31:0] hour32;
        assign hour32 = 32'(src[F_HOUR*FIELD_W +: FIELD_W]);
        assign pm_d   = (hour32 >= 32'd12) && (hour32 < LIM_HOUR);
    end else begin : g_no_pm
        assign pm_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            all_hex      <= {(FIELDS*2){BLANK_OUT}};
            pm_flag      <= 1'b0;
            cnt          <= '0;
            phase        <= PHASE_ON;
            edit_mode_q  <= 1'b0;
            edit_field_q <= '0;
        end else begin
            all_hex      <= hex_d;
            pm_flag      <= pm_d;
            edit_mode_q  <= edit_mode;
            edit_field_q <= edit_field;
            if (!edit_mode || restart) begin
                cnt   <= '0;
                phase <= PHASE_ON;
            end else if (cnt == CNT_LAST) begin
                cnt   <= '0;
                phase <= (phase == PHASE_ON) ? PHASE_OFF : PHASE_ON;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_time_display_ctrl.sv
module tb_time_display_ctrl;

    typedef struct {
        logic [41:0] hex;
        logic        pm;
        logic        blink;
    } exp_t;

    // Active-low digit codes 0..9
    localparam logic [6:0] SEGTAB [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                           7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    logic        clk = 1'b0;
    logic        rst;
    logic [17:0] time_live;
    logic [17:0] time_edit;
    logic        set_en;
    logic        alarm_en;
    logic [1:0]  edit_field;
    logic        mode_12h;
    logic [41:0] all_hex;
    logic        pm_flag;
    logic        blink_on;

    int   errors = 0;
    int   checks = 0;
    exp_t q[$];

    // reference model state
    int   m_cnt   = 0;
    logic m_blink = 1'b1;
    logic m_emq   = 1'b0;
    logic [1:0] m_efq = 2'd0;

    time_display_ctrl #(
        .FIELDS     (3),
        .FIELD_W    (6),
        .BLINK_DIV  (4),
        .SEG_ACT_LOW(1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .time_live (time_live),
        .time_edit (time_edit),
        .set_en    (set_en),
        .alarm_en  (alarm_en),
        .edit_field(edit_field),
        .mode_12h  (mode_12h),
        .all_hex   (all_hex),
        .pm_flag   (pm_flag),
        .blink_on  (blink_on)
    );

    always #5 clk = ~clk;

    function automatic logic [17:0] pack(input int h, input int m, input int s);
        return {6'(h), 6'(m), 6'(s)};
    endfunction

    function automatic logic [41:0] model_hex(input logic [17:0] src, input logic em,
                                              input logic [1:0] ef, input logic vis,
                                              input logic m12);
        logic [41:0] r;
        r = '0;
        for (int k = 0; k < 3; k++) begin
            int v;
            int lim;
            int d;
            logic [6:0] t;
            logic [6:0] o;
            v   = int'(src[6*k +: 6]);
            lim = (k == 2) ? 24 : 60;
            if (em && (int'(ef) == k + 1) && !vis) begin
                t = 7'h7F; o = 7'h7F;
            end else if (v >= lim) begin
                t = 7'h3F; o = 7'h3F;
            end else begin
                d = v;
                if (k == 2 && m12) begin
                    if (v == 0) d = 12;
                    else if (v > 12) d = v - 12;
                end
                t = SEGTAB[d / 10];
                o = SEGTAB[d % 10];
            end
            r[14*k +: 7]   = o;
            r[14*k+7 +: 7] = t;
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Predict the next registered outputs from current inputs, clock once, compare.
    task automatic step(input string tag);
        exp_t        e;
        exp_t        got;
        logic        em;
        logic        restart;
        logic        vis;
        logic [17:0] src;
        int          h;
        em      = set_en | alarm_en;
        restart = em && (!m_emq || (edit_field != m_efq));
        vis     = m_blink || restart;
        src     = em ? time_edit : time_live;
        h       = int'(src[17:12]);
        e.hex   = model_hex(src, em, edit_field, vis, mode_12h);
        e.pm    = (h >= 12) && (h < 24);
        if (rst) begin
            e.hex   = '1;
            e.pm    = 1'b0;
            m_cnt   = 0;
            m_blink = 1'b1;
            m_emq   = 1'b0;
            m_efq   = 2'd0;
        end else begin
            if (!em || restart) begin
                m_cnt = 0; m_blink = 1'b1;
            end else if (m_cnt == 3) begin
                m_cnt = 0; m_blink = !m_blink;
            end else begin
                m_cnt++;
            end
            m_emq = em;
            m_efq = edit_field;
        end
        e.blink = m_blink;
        q.push_back(e);
        @(posedge clk);
        #1;
        got = q.pop_front();
        check({tag, "_hex"},   64'(all_hex),  64'(got.hex));
        check({tag, "_pm"},    64'(pm_flag),  64'(got.pm));
        check({tag, "_blink"}, 64'(blink_on), 64'(got.blink));
    endtask

    initial begin
        int guard;
        rst        = 1'b1;
        time_live  = '0;
        time_edit  = '0;
        set_en     = 1'b0;
        alarm_en   = 1'b0;
        edit_field = 2'd0;
        mode_12h   = 1'b0;

        // reset state
        step("rst0");
        step("rst1");
        check("rst_all_off", 64'(all_hex), 64'(42'h3FF_FFFF_FFFF));

        // live 12:34:56
        rst       = 1'b0;
        time_live = pack(12, 34, 56);
        step("live");
        check("sec_ones", 64'(all_hex[6:0]),   64'(7'h02));
        check("sec_tens", 64'(all_hex[13:7]),  64'(7'h12));
        check("hr_tens",  64'(all_hex[41:35]), 64'(7'h79));

        // edit minutes: blinking every 4 clocks
        set_en     = 1'b1;
        edit_field = 2'd2;
        time_edit  = pack(12, 7, 45);
        for (int i = 0; i < 12; i++) step("blink_min");

        // 12-hour conversion
        set_en     = 1'b0;
        edit_field = 2'd0;
        mode_12h   = 1'b1;
        time_live  = pack(0, 10, 20);
        step("h00_12h");
        time_live  = pack(13, 10, 20);
        step("h13_12h");
        check("h13_tens", 64'(all_hex[41:35]), 64'(7'h40));
        time_live  = pack(12, 10, 20);
        step("h12_12h");
        mode_12h   = 1'b0;
        time_live  = pack(23, 10, 20);
        step("h23_24h");

        // out of range
        time_live  = pack(10, 61, 20);
        step("min61");
        check("min61_dash", 64'(all_hex[27:14]), 64'({7'h3F, 7'h3F}));
        time_live  = pack(30, 10, 20);
        step("hr30");
        check("hr30_pm", 64'(pm_flag), 64'(1'b0));

        // field change exactly on the toggle cycle restarts the timer
        set_en     = 1'b1;
        edit_field = 2'd1;
        time_edit  = pack(14, 22, 33);
        guard = 0;
        do begin
            step("pre_toggle");
            guard++;
        end while (m_cnt != 3 && guard < 10);
        check("reach_toggle", 64'(guard < 10), 64'(1'b1));
        edit_field = 2'd3;
        step("ef_change");
        check("restart_vis", 64'(blink_on), 64'(1'b1));
        for (int i = 0; i < 4; i++) step("after_restart");
        check("toggle_at_4", 64'(blink_on), 64'(1'b0));

        // both edit enables: edit buffer shown
        alarm_en  = 1'b1;
        time_live = pack(1, 2, 3);
        step("both_en");
        guard = 0;
        while (m_blink != 1'b0 && guard < 10) begin
            step("wait_off");
            guard++;
        end
        check("reach_off", 64'(guard < 10), 64'(1'b1));

        // reset mid-blink
        rst = 1'b1;
        step("rst_mid");
        rst = 1'b0;
        step("post_rst");

        // timer frozen while not editing
        set_en   = 1'b0;
        alarm_en = 1'b0;
        for (int i = 0; i < 6; i++) step("frozen");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
